// File: rtl/mem_pkg.sv
// mem_pkg: store-type encodings and lane helper shared by the store path.
package mem_pkg;
  localparam logic [3:0] ST_NONE  = 4'b0000;
  localparam logic [3:0] ST_WORD  = 4'b0001;
  localparam logic [3:0] ST_BYTE  = 4'b0010;
  localparam logic [3:0] ST_HALF  = 4'b0011;
  localparam logic [3:0] ST_DWORD = 4'b0100;
  function automatic int lanes(int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/store_align.sv
// store_align: places store data on its byte lanes and flags misaligned or invalid stores.
module store_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANES = lanes(DATA_W),
  localparam int OFF_W = $clog2(LANES)
) (
  input  logic [3:0]        st_type,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] wdata,
  output logic [LANES-1:0]  byteen,
  output logic              misaligned,
  output logic              type_valid
);
  logic is_byte, is_half, is_word, is_dword;
  logic [DATA_W-1:0] mask;
  logic [LANES-1:0] base;
  always_comb begin
    is_byte = st_type == ST_BYTE;
    is_half = st_type == ST_HALF;
    is_word = st_type == ST_WORD;
    is_dword = st_type == ST_DWORD && DATA_W == 64;
    type_valid = is_byte || is_half || is_word || is_dword;
    misaligned = (is_half && off[0]) || (is_word && off[1:0] != 2'b00) || (is_dword && off != '0);
    mask = is_dword ? '1 : is_word ? DATA_W'(32'hffff_ffff) : is_half ? DATA_W'(16'hffff) :
           is_byte ? DATA_W'(8'hff) : '0;
    base = is_dword ? '1 : is_word ? LANES'(4'hf) : is_half ? LANES'(2'b11) :
           is_byte ? LANES'(1'b1) : '0;
    wdata = (st_data & mask) << {off, 3'b000};
    byteen = base << off;
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of lane-aligned stores drained to memory, with load-address hit detection.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  localparam int LANES = lanes(DATA_W),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [3:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_excp,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [LANES-1:0]  mem_byteen,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hit,
  output logic [CW-1:0]     count,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int OFF_W = $clog2(LANES);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  byteen;
  } entry_t;
  entry_t fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] wdata;
  logic [LANES-1:0] byteen;
  logic misaligned, type_valid, push, pop;
  logic [ADDR_W-1:0] line_mask;
  store_align #(.DATA_W(DATA_W)) u_align (
    .st_type    (st_type),
    .off        (st_addr[OFF_W-1:0]),
    .st_data    (st_data),
    .wdata      (wdata),
    .byteen     (byteen),
    .misaligned (misaligned),
    .type_valid (type_valid)
  );
  assign line_mask = ~ADDR_W'(LANES - 1);
  assign empty = count == '0;
  assign st_ready = count != CW'(DEPTH);
  assign mem_valid = !empty;
  assign st_excp = st_valid && type_valid && misaligned;
  assign push = st_valid && st_ready && type_valid && !misaligned;
  assign pop = mem_valid && mem_ready;
  assign mem_addr = empty ? '0 : fifo[rd_ptr].addr;
  assign mem_wdata = empty ? '0 : fifo[rd_ptr].wdata;
  assign mem_byteen = empty ? '0 : fifo[rd_ptr].byteen;
  // Entry i is occupied when its distance from the head is below count.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      ld_hit = ld_hit || (ld_valid && CW'(PW'(i) - rd_ptr) < count && fifo[i].addr == (ld_addr & line_mask));
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= '{addr: st_addr & line_mask, wdata: wdata, byteen: byteen};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a queue-based store model.
module tb_store_buffer;
  typedef struct {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } ent_t;

  logic clk = 1'b0, reset = 1'b1;
  logic sv = 1'b0, mr = 1'b0, lv = 1'b0;
  logic [3:0] st = 4'd0;
  logic [31:0] sa = '0, la = '0, sd = '0;
  logic st_ready, st_excp, mem_valid, ld_hit, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_byteen;
  logic [2:0] count;

  logic sv64 = 1'b0, mr64 = 1'b0;
  logic [3:0] st64 = 4'd0;
  logic [31:0] sa64 = '0;
  logic [63:0] sd64 = '0;
  logic st_ready64, st_excp64, mem_valid64, ld_hit64, empty64;
  logic [31:0] mem_addr64;
  logic [63:0] mem_wdata64;
  logic [7:0] mem_byteen64;
  logic [2:0] count64;

  int checks = 0, failures = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .st_valid(sv), .st_ready(st_ready), .st_type(st),
    .st_addr(sa), .st_data(sd), .st_excp(st_excp), .mem_valid(mem_valid),
    .mem_ready(mr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .ld_valid(lv), .ld_addr(la), .ld_hit(ld_hit), .count(count), .empty(empty)
  );

  store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .st_valid(sv64), .st_ready(st_ready64), .st_type(st64),
    .st_addr(sa64), .st_data(sd64), .st_excp(st_excp64), .mem_valid(mem_valid64),
    .mem_ready(mr64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64), .mem_byteen(mem_byteen64),
    .ld_valid(1'b0), .ld_addr(32'h0), .ld_hit(ld_hit64), .count(count64), .empty(empty64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a store of `size` bytes is legal if it fits the bus and its offset is a multiple of its size.
  task automatic model(input logic [3:0] t, input logic [31:0] a, input logic [63:0] d, input int nl,
                       output bit ok, output bit mis, output ent_t e);
    int size, off;
    size = (t == 4'd2) ? 1 : (t == 4'd3) ? 2 : (t == 4'd1) ? 4 : (t == 4'd4) ? 8 : 0;
    off = int'(a % nl);
    ok = size > 0 && size <= nl;
    mis = ok && (off % size) != 0;
    e.addr = a - off;
    e.wdata = '0;
    e.be = '0;
    for (int k = 0; k < size && !mis && ok; k++) begin
      e.wdata[(off + k) * 8 +: 8] = d[k * 8 +: 8];
      e.be[off + k] = 1'b1;
    end
  endtask

  // One clock: check every output against the model, then advance the model across the edge.
  task automatic cyc();
    bit ok, mis, hit, do_push, do_pop;
    ent_t e;
    #1;
    model(st, sa, {32'h0, sd}, 4, ok, mis, e);
    hit = 1'b0;
    foreach (q[i]) if (lv && q[i].addr == (la & ~32'h3)) hit = 1'b1;
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("st_ready", st_ready, q.size() < 4);
    chk("mem_valid", mem_valid, q.size() > 0);
    chk("st_excp", st_excp, sv && mis);
    chk("ld_hit", ld_hit, hit);
    chk("mem_addr", mem_addr, q.size() ? q[0].addr : 0);
    chk("mem_wdata", mem_wdata, q.size() ? q[0].wdata : 0);
    chk("mem_byteen", mem_byteen, q.size() ? q[0].be : 0);
    do_push = sv && q.size() < 4 && ok && !mis;
    do_pop = mr && q.size() > 0;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    #1;
  endtask

  task automatic store(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
    sv = 1'b1; st = t; sa = a; sd = d;
    cyc();
    sv = 1'b0;
  endtask

  task automatic drain();
    mr = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    mr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();
    chk("reset_count", count, 0);
    chk("reset_st_ready", st_ready, 1);
    store(4'd2, 32'h13, 32'hAB);
    chk("byte_wdata", mem_wdata, 32'hAB000000);
    chk("byte_addr", mem_addr, 32'h10);
    chk("byte_be", mem_byteen, 4'b1000);
    drain();
    store(4'd3, 32'h22, 32'h1234);
    chk("half_be", mem_byteen, 4'b1100);
    drain();
    sv = 1'b1; st = 4'd3; sa = 32'h21; #1;
    chk("half_mis_excp", st_excp, 1);
    store(4'd3, 32'h21, 32'h5678);
    chk("half_mis_count", count, 0);
    store(4'd0, 32'h40, 32'h1);
    chk("type0_count", count, 0);
    for (int i = 0; i < 4; i++) store(4'd1, 32'h100 + 4 * i, 32'hC0DE0000 + i);
    chk("full_count", count, 4);
    chk("full_ready", st_ready, 0);
    store(4'd1, 32'h200, 32'hDEAD);
    chk("hold_addr", mem_addr, 32'h100);
    mr = 1'b1;
    store(4'd1, 32'h200, 32'hBEEF);
    chk("refused_count", count, 3);
    mr = 1'b0;
    drain();
    store(4'd1, 32'h10, 32'h11);
    store(4'd1, 32'h14, 32'h22);
    mr = 1'b1;
    store(4'd1, 32'h18, 32'h33);
    chk("pushpop_count", count, 2);
    mr = 1'b0;
    drain();
    store(4'd1, 32'h104, 32'h77);
    lv = 1'b1; la = 32'h107; #1;
    chk("ld_hit_same", ld_hit, 1);
    la = 32'h108; #1;
    chk("ld_hit_next", ld_hit, 0);
    la = 32'h104;
    drain();
    chk("ld_hit_drained", ld_hit, 0);
    lv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sv = 1'($urandom); st = 4'($urandom_range(0, 5)); sa = 32'h100 + $urandom_range(0, 31);
      sd = $urandom; mr = 1'($urandom); lv = 1'($urandom); la = 32'h100 + $urandom_range(0, 31);
      cyc();
    end
    sv = 1'b0; lv = 1'b0; mr = 1'b0;
    for (int i = 0; i < 3; i++) store(4'd1, 32'h300 + 4 * i, i);
    reset = 1'b1;
    @(posedge clk);
    q.delete();
    #1 reset = 1'b0;
    chk("rst_mid_valid", mem_valid, 0);
    chk("rst_mid_count", count, 0);
    cyc();
    sv64 = 1'b1; st64 = 4'd4; sa64 = 32'h4; sd64 = 64'h1122334455667788; #1;
    chk("dw_mis_excp", st_excp64, 1);
    sa64 = 32'h8; #1;
    chk("dw_ok_excp", st_excp64, 0);
    @(posedge clk); #1;
    sv64 = 1'b0;
    chk("dw_count", count64, 1);
    chk("dw_be", mem_byteen64, 8'hFF);
    chk("dw_addr", mem_addr64, 32'h8);
    chk("dw_wdata", mem_wdata64, 64'h1122334455667788);
    sv64 = 1'b1; st64 = 4'd1; sa64 = 32'h14; sd64 = 64'hFFFF_FFFF_CAFE_F00D;
    @(posedge clk); #1;
    sv64 = 1'b0; mr64 = 1'b1;
    @(posedge clk); #1;
    mr64 = 1'b0;
    chk("w64_be", mem_byteen64, 8'hF0);
    chk("w64_wdata", mem_wdata64, 64'hCAFEF00D_00000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
